// File: rtl/edge_threshold_pkg.sv
// Shared pixel-stream types and widths for the Sobel back-end stages.
// Widths are sized for the maximum frame; smaller frames reuse the same port widths.
package edge_threshold_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int MAG_WIDTH  = DATA_WIDTH + 3;
    localparam int IMG_WIDTH  = 640;
    localparam int IMG_HEIGHT = 480;
    localparam int COL_W      = $clog2(IMG_WIDTH);
    localparam int ROW_W      = $clog2(IMG_HEIGHT);
    localparam int CNT_W      = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

    typedef logic [COL_W-1:0]      col_t;
    typedef logic [ROW_W-1:0]      row_t;
    typedef logic [DATA_WIDTH-1:0] pixel_t;
    typedef logic [MAG_WIDTH-1:0]  mag_t;

    typedef struct packed {
        col_t col;
        row_t row;
    } pixel_pos_t;

    function automatic pixel_t saturate(input mag_t s);
        return (|s[MAG_WIDTH-1:DATA_WIDTH]) ? '1 : s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/edge_threshold_if.sv
// Pixel stream bundle between the convolution core (master) and edge_threshold (slave).
interface edge_threshold_if import edge_threshold_pkg::*;;

    logic                 i_val_valid;
    mag_t                 i_val;
    logic                 i_sof;
    logic                 i_thresh_en;
    pixel_t               i_threshold;
    logic                 o_val_valid;
    pixel_t               o_val;
    col_t                 o_col;
    row_t                 o_row;
    logic                 o_frame_done;
    logic [CNT_W-1:0]     o_edge_count;

    modport master (
        output i_val_valid, i_val, i_sof, i_thresh_en, i_threshold,
        input  o_val_valid, o_val, o_col, o_row, o_frame_done, o_edge_count
    );

    modport slave (
        input  i_val_valid, i_val, i_sof, i_thresh_en, i_threshold,
        output o_val_valid, o_val, o_col, o_row, o_frame_done, o_edge_count
    );

endinterface

// File: rtl/edge_threshold_pixel_pos_counter.sv
// Column/row tracker for a raster pixel stream; pos_o is the position of the pixel
// presented this cycle (sof forces it to (0,0)).
module pixel_pos_counter
    import edge_threshold_pkg::*;
#(
    parameter int FRAME_W = IMG_WIDTH,
    parameter int FRAME_H = IMG_HEIGHT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic       sof_i,
    output pixel_pos_t pos_o,
    output logic       last_o
);

    col_t       col_q, col_d;
    row_t       row_q, row_d;
    pixel_pos_t pos;
    logic       end_of_line;

    always_comb begin
        pos = sof_i ? '0 : pixel_pos_t'{col: col_q, row: row_q};
        end_of_line = (pos.col == COL_W'(FRAME_W - 1));
        last_o = end_of_line && (pos.row == ROW_W'(FRAME_H - 1));
        pos_o = pos;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_i) begin
            if (end_of_line) begin
                col_d = '0;
                row_d = last_o ? '0 : row_t'(pos.row + 1'b1);
            end else begin
                col_d = col_t'(pos.col + 1'b1);
                row_d = pos.row;
            end
        end else if (sof_i) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/edge_threshold.sv
// Scales/saturates Sobel magnitudes, blanks warm-up borders, optionally binarises
// against a per-frame threshold and counts edge pixels. Two-stage pipeline, no stalls.
module edge_threshold
    import edge_threshold_pkg::*;
#(
    parameter int N       = 3,
    parameter int SHIFT   = 2,
    parameter int FRAME_W = IMG_WIDTH,
    parameter int FRAME_H = IMG_HEIGHT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    edge_threshold_if.slave  bus
);

    pixel_pos_t cur_pos;
    logic       cur_last;

    pixel_pos_counter #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H)
    ) u_pos (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .valid_i (bus.i_val_valid),
        .sof_i   (bus.i_sof),
        .pos_o   (cur_pos),
        .last_o  (cur_last)
    );

    // stage 1
    mag_t   mag_shift;
    pixel_t sat_d;
    logic   border_d;
    logic   first_d;

    logic       s1_valid_q;
    pixel_t     s1_sat_q;
    logic       s1_border_q;
    pixel_pos_t s1_pos_q;
    logic       s1_last_q;
    logic       s1_clr_q;
    pixel_t     thr_q;
    logic       en_q;

    always_comb begin
        mag_shift = bus.i_val >> SHIFT;
        sat_d     = saturate(mag_shift);
        border_d  = (cur_pos.col < COL_W'(N - 1)) || (cur_pos.row < ROW_W'(N - 1));
        first_d   = bus.i_val_valid && (cur_pos == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sat_q    <= '0;
            s1_border_q <= 1'b0;
            s1_pos_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_clr_q    <= 1'b0;
            thr_q       <= '0;
            en_q        <= 1'b0;
        end else begin
            s1_valid_q <= bus.i_val_valid;
            // Running count restarts whenever a frame (re)starts, travelling with the pixel
            // so edges still in flight from the previous frame land before the clear.
            s1_clr_q   <= first_d || bus.i_sof;
            if (bus.i_val_valid) begin
                s1_sat_q    <= sat_d;
                s1_border_q <= border_d;
                s1_pos_q    <= cur_pos;
                s1_last_q   <= cur_last;
            end
            if (first_d) begin
                thr_q <= bus.i_threshold;
                en_q  <= bus.i_thresh_en;
            end
        end
    end

    // stage 2
    logic             hit;
    logic             is_edge;
    pixel_t           pix_d;
    logic [CNT_W-1:0] run_inc;

    logic             out_valid_q;
    pixel_t           out_val_q;
    pixel_pos_t       out_pos_q;
    logic             frame_done_q;
    logic [CNT_W-1:0] edge_count_q;
    logic [CNT_W-1:0] run_q;

    always_comb begin
        hit     = (s1_sat_q >= thr_q);
        is_edge = s1_valid_q && en_q && !s1_border_q && hit;
        pix_d   = s1_sat_q;
        if (s1_border_q) begin
            pix_d = '0;
        end else if (en_q) begin
            pix_d = hit ? '1 : '0;
        end
        run_inc = run_q + CNT_W'(is_edge);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_q  <= 1'b0;
            out_val_q    <= '0;
            out_pos_q    <= '0;
            frame_done_q <= 1'b0;
            edge_count_q <= '0;
            run_q        <= '0;
        end else begin
            out_valid_q  <= s1_valid_q;
            frame_done_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                out_val_q <= pix_d;
                out_pos_q <= s1_pos_q;
            end
            if (s1_clr_q) begin
                run_q <= CNT_W'(is_edge);
            end else if (s1_valid_q && s1_last_q) begin
                edge_count_q <= run_inc;
                run_q        <= '0;
            end else begin
                run_q <= run_inc;
            end
        end
    end

    assign bus.o_val_valid  = out_valid_q;
    assign bus.o_val        = out_val_q;
    assign bus.o_col        = out_pos_q.col;
    assign bus.o_row        = out_pos_q.row;
    assign bus.o_frame_done = frame_done_q;
    assign bus.o_edge_count = edge_count_q;

endmodule

// File: tb/tb_edge_threshold.sv
// Scoreboard bench for edge_threshold on a reduced 40x30 frame.
module tb_edge_threshold;
    import edge_threshold_pkg::*;

    localparam int W = 40;
    localparam int H = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_threshold_if bus ();

    edge_threshold #(
        .N       (3),
        .SHIFT   (2),
        .FRAME_W (W),
        .FRAME_H (H)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int val;
        int col;
        int row;
        bit fd;
        int cnt;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    int   mcol = 0, mrow = 0, mrun = 0, mcnt = 0;
    bit   men = 1'b0;
    int   mthr = 0;
    bit   tb_en = 1'b0;
    int   tb_thr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.o_val_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("val", bus.o_val, e.val);
                check("col", bus.o_col, e.col);
                check("row", bus.o_row, e.row);
                check("frame_done", bus.o_frame_done, e.fd);
                check("latency", cyc - e.cyc, 2);
                if (e.fd) check("edge_count", bus.o_edge_count, e.cnt);
            end
        end else if (rst_n && bus.o_frame_done) begin
            check("frame_done_no_valid", 1, 0);
        end
    end

    task automatic drive(input bit v, input int val, input bit sof);
        exp_t e;
        int   s, sat, expv;
        bit   border, hit, edge_px, last;
        @(posedge clk);
        #1;
        bus.i_val_valid = v;
        bus.i_val       = MAG_WIDTH'(val);
        bus.i_sof       = sof;
        bus.i_thresh_en = tb_en;
        bus.i_threshold = DATA_WIDTH'(tb_thr);
        if (sof) begin
            mcol = 0; mrow = 0; mrun = 0;
        end
        if (v) begin
            if (mcol == 0 && mrow == 0) begin
                men  = tb_en;
                mthr = tb_thr;
            end
            s       = val >> 2;
            sat     = (s > 4095) ? 4095 : s;
            border  = (mcol < 2) || (mrow < 2);
            hit     = (sat >= mthr);
            expv    = border ? 0 : (men ? (hit ? 4095 : 0) : sat);
            edge_px = men && !border && hit;
            last    = (mcol == W - 1) && (mrow == H - 1);
            e.cnt   = 0;
            if (last) begin
                mcnt  = mrun + int'(edge_px);
                mrun  = 0;
                e.cnt = mcnt;
            end else begin
                mrun += int'(edge_px);
            end
            e.val = expv; e.col = mcol; e.row = mrow; e.fd = last; e.cyc = cyc;
            sb.push_back(e);
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow++;
                if (mrow == H) mrow = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    initial begin
        bus.i_val_valid = 1'b0;
        bus.i_val       = '0;
        bus.i_sof       = 1'b0;
        bus.i_thresh_en = 1'b0;
        bus.i_threshold = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.o_val_valid, 0);
        check("rst_val", bus.o_val, 0);
        check("rst_frame_done", bus.o_frame_done, 0);
        check("rst_edge_count", bus.o_edge_count, 0);
        #2 rst_n = 1'b1;

        // border pixel at (0,0), then interior (5,5) saturated and (6,5) scaled
        tb_en = 1'b0; tb_thr = 0;
        drive(1'b1, 100, 1'b1);
        for (int p = 1; p <= 5 * W + 6; p++) begin
            if (p == 5 * W + 5)      drive(1'b1, 'h7FFF, 1'b0);
            else if (p == 5 * W + 6) drive(1'b1, 400, 1'b0);
            else                     drive(1'b1, $urandom_range(0, 'h7FFF), 1'b0);
        end

        // binarised frame; threshold changes mid-frame must not apply
        tb_en = 1'b1; tb_thr = 100;
        for (int p = 0; p < W * H; p++) begin
            if (p == 10) begin tb_en = 1'b0; tb_thr = 0; end
            if (p == 5 * W + 5)      drive(1'b1, 400, 1'b0);
            else if (p == 5 * W + 6) drive(1'b1, 396, 1'b0);
            else if (p == 5 * W + 7) drive(1'b1, 404, 1'b0);
            else                     drive(1'b1, $urandom_range(0, 800), p == 0);
        end

        // full uniform frame, entered by natural wrap
        tb_en = 1'b1; tb_thr = 100;
        for (int p = 0; p < W * H; p++) drive(1'b1, 400, 1'b0);
        idle(4);
        check("edge_count_full", bus.o_edge_count, (W - 2) * (H - 2));
        check("drain_full", sb.size(), 0);

        // gapped stream, sof with valid at (10,3), sof without valid
        tb_en = 1'b0;
        while (!(mcol == 10 && mrow == 3))
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 'h7FFF), 1'b0);
        drive(1'b1, 400, 1'b1);
        for (int i = 0; i < 60; i++)
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 'h7FFF), 1'b0);
        drive(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom_range(0, 'h7FFF), 1'b0);
        idle(4);
        check("edge_count_kept", bus.o_edge_count, (W - 2) * (H - 2));
        check("drain_gaps", sb.size(), 0);

        // async reset with pixels in flight
        tb_en = 1'b1; tb_thr = 50;
        for (int i = 0; i < 4; i++) drive(1'b1, 1000, 1'b0);
        #1;
        bus.i_val_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        mcol = 0; mrow = 0; mrun = 0; mcnt = 0; men = 1'b0; mthr = 0;
        repeat (2) @(negedge clk);
        check("rst_mid_valid", bus.o_val_valid, 0);
        check("rst_mid_edge_count", bus.o_edge_count, 0);
        #2 rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 3; i++) drive(1'b1, 2000, 1'b0);
        idle(4);
        check("drain_after_reset", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
